mem_stage_seq: RTL and testbench
================================

# mem_stage_seq

Memory-stage sequencer of the vector pipeline: consumes the execute/memory bundle (mem control, wb control, ALU results, store data, destination) and performs the scalar or vector data-memory access it encodes. A 192-bit vector is moved lane by lane over a 24-bit data-memory port. The block stalls upstream while busy and emits the memory/writeback bundle once the access completes.

## Interface
- LANES, 8, vector lanes per register
- LANE_W, 24, bits per lane; the vector is LANES*LANE_W = 192 bits
- ADDR_W, 21, scalar/address width
- DEST_W, 4, destination register index width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  execute/memory bundle present
- in_ready  out  1  block accepts bundle this cycle
- mem  in  4  [0]=read, [1]=write, [2]=vector, [3] reserved (ignored)
- wb  in  2  writeback control, passed through
- resALUe  in  ADDR_W  scalar ALU result; base address for memory ops
- resALUve  in  192  vector ALU result, passed through
- r2e  in  ADDR_W  scalar store data
- r2v  in  192  vector store data, lane i = bits [24i+23:24i]
- dest  in  DEST_W  destination, passed through
- dm_req  out  1  memory request
- dm_we  out  1  1=write, 0=read; valid with dm_req
- dm_addr  out  ADDR_W  word address
- dm_wdata  out  LANE_W  write data
- dm_ack  in  1  request accepted/completed this cycle; rdata valid on reads
- dm_rdata  in  LANE_W  read data
- out_valid  out  1  one-cycle pulse, bundle below valid
- wb_out  out  2, dest_out  out  DEST_W, resALUe_out  out  ADDR_W, resALUve_out  out  192  registered pass-throughs
- lde_out  out  ADDR_W  scalar load result
- ldv_out  out  192  vector load result
- stall  out  1  equals !in_ready

## Operation
- States: IDLE, XFER, DONE. Reset state IDLE; every output 0, in_ready 1 in IDLE.
- IDLE, in_valid=1: latch whole bundle. If mem[0]|mem[1] = 0 → DONE. Otherwise lane counter := 0 → XFER. If mem[0] and mem[1] both set, write wins.
- XFER: dm_req=1, dm_addr = base + lane (modulo 2^ADDR_W, wraps silently), dm_we=mem[1], dm_wdata = lane of r2v (vector) or zero-extended r2e (scalar). Outputs hold until dm_ack.
- On dm_ack: read stores dm_rdata into ldv_out lane (vector) or dm_rdata[ADDR_W-1:0] into lde_out (scalar). Last beat (scalar: beat 0; vector: lane LANES-1) → DONE, else lane+1, dm_req stays high.
- DONE: out_valid=1 for one cycle, → IDLE. Load results not written by this op read as 0 (cleared on accept).
- in_ready=1 only in IDLE; in_valid while busy is ignored. dm_ack outside XFER is ignored.

## Timing
- Non-memory op: accept at edge N, out_valid at N+1.
- Scalar access: out_valid one cycle after ack edge.
- Vector access with zero wait states (ack tied high): accept N, lanes N+1..N+8, out_valid N+9 → 10 cycles per op; next accept N+10.
- rst mid-XFER: dm_req drops asynchronously, transfer abandoned, partial loads discarded, no out_valid.

## Configuration
- VMEM_ALIGN_CHECK_EN defined: vector access with base[2:0] ≠ 0 performs no memory beats, goes straight to DONE, extra output align_err (1 bit) pulses with out_valid; ldv_out = 0.
- Undefined: no check, no align_err port; misaligned bases access base..base+7 with wrap.

## Structure
- Package vp_pkg: LANES, LANE_W, ADDR_W, DEST_W constants; mem-field bit indices (MEM_RD, MEM_WR, MEM_VEC); state enum.
- One sub-module: mem_lane_counter (lane index, last-lane flag, address add with wrap).

## Test plan
- mem=4'b0000, resALUe=21'h00ABC → no dm_req, out_valid next cycle, resALUe_out=21'h00ABC.
- Vector store mem=4'b0110, base 21'h000010, r2v lanes 0x000001..0x000008, ack high → 8 writes to 0x10..0x17 with those data, out_valid at cycle 9.
- Scalar load mem=4'b0001, base 21'h000100, ack after 3 wait cycles, rdata 24'hF12345 → lde_out=21'h112345, stall high throughout.
- Vector load base 21'h1FFFFC → addresses 1FFFFC..1FFFFF,000000..000003; ldv_out lane i = returned word i.
- Assert rst during lane 4 of vector store → dm_req 0 immediately, no out_valid, next op accepted normally.
- VMEM_ALIGN_CHECK_EN, vector load base 21'h000013 → no dm_req, align_err=1 with out_valid, ldv_out=0.

Source files
------------

// File: rtl/vp_pkg.sv
// rtl/vp_pkg.sv - shared constants, mem-field bit indices and FSM state type for the memory stage
// Optional feature macro used by importers: VMEM_ALIGN_CHECK_EN
package vp_pkg;

  localparam int LANES      = 8;
  localparam int LANE_W     = 24;
  localparam int ADDR_W     = 21;
  localparam int DEST_W     = 4;
  localparam int VEC_W      = LANES * LANE_W;
  localparam int LANE_IDX_W = $clog2(LANES);

  localparam int MEM_RD  = 0;
  localparam int MEM_WR  = 1;
  localparam int MEM_VEC = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [LANE_W-1:0] get_lane(input logic [VEC_W-1:0]      v,
                                                 input logic [LANE_IDX_W-1:0] idx);
    return v[idx*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/mem_lane_counter.sv
// rtl/mem_lane_counter.sv - lane index for multi-beat accesses, last-lane flag and wrapping beat address
module mem_lane_counter
  import vp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  input  logic [ADDR_W-1:0]     base,
  output logic [LANE_IDX_W-1:0] lane,
  output logic                  last,
  output logic [ADDR_W-1:0]     addr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane <= '0;
    end else if (clr) begin
      lane <= '0;
    end else if (inc) begin
      lane <= lane + 1'b1;
    end
  end

  assign last = (lane == LANE_IDX_W'(LANES - 1));
  // Address arithmetic is modulo 2^ADDR_W; a carry out of the top bit is simply dropped.
  assign addr = base + ADDR_W'(lane);

endmodule

// File: rtl/mem_stage_seq.sv
// rtl/mem_stage_seq.sv - memory-stage sequencer: scalar or lane-by-lane vector access over a 24-bit port
// Define VMEM_ALIGN_CHECK_EN to reject vector accesses whose base is not 8-word aligned (adds align_err).
module mem_stage_seq
  import vp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        mem,
  input  logic [1:0]        wb,
  input  logic [ADDR_W-1:0] resALUe,
  input  logic [VEC_W-1:0]  resALUve,
  input  logic [ADDR_W-1:0] r2e,
  input  logic [VEC_W-1:0]  r2v,
  input  logic [DEST_W-1:0] dest,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [LANE_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [LANE_W-1:0] dm_rdata,
  output logic              out_valid,
  output logic [1:0]        wb_out,
  output logic [DEST_W-1:0] dest_out,
  output logic [ADDR_W-1:0] resALUe_out,
  output logic [VEC_W-1:0]  resALUve_out,
  output logic [ADDR_W-1:0] lde_out,
  output logic [VEC_W-1:0]  ldv_out,
`ifdef VMEM_ALIGN_CHECK_EN
  output logic              align_err,
`endif
  output logic              stall
);

  state_t state, nstate;

  logic [2:0]            mem_q;
  logic [1:0]            wb_q;
  logic [DEST_W-1:0]     dest_q;
  logic [ADDR_W-1:0]     base_q;
  logic [VEC_W-1:0]      aluv_q;
  logic [ADDR_W-1:0]     r2e_q;
  logic [VEC_W-1:0]      r2v_q;
  logic [ADDR_W-1:0]     lde_q;
  logic [VEC_W-1:0]      ldv_q;

  logic                  accept;
  logic                  is_access;
  logic                  misalign;
  logic                  beat_done;
  logic                  last_beat;
  logic                  rd_only;
  logic [LANE_IDX_W-1:0] lane;
  logic                  lane_last;
  logic [ADDR_W-1:0]     lane_addr;
  logic                  mem_unused;

  assign mem_unused = mem[3];
  assign accept     = (state == ST_IDLE) && in_valid;
  assign is_access  = mem[MEM_RD] | mem[MEM_WR];
  assign beat_done  = (state == ST_XFER) && dm_ack;
  assign last_beat  = mem_q[MEM_VEC] ? lane_last : 1'b1;
  // Read-and-write encodings are treated as writes, so loads only land for pure reads.
  assign rd_only    = mem_q[MEM_RD] & ~mem_q[MEM_WR];

`ifdef VMEM_ALIGN_CHECK_EN
  logic aerr_q;
  assign misalign = mem[MEM_VEC] && (resALUe[2:0] != 3'b000);
`else
  assign misalign = 1'b0;
`endif

  mem_lane_counter u_lane (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .inc  (beat_done && !last_beat),
    .base (base_q),
    .lane (lane),
    .last (lane_last),
    .addr (lane_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE: if (in_valid) nstate = (is_access && !misalign) ? ST_XFER : ST_DONE;
      ST_XFER: if (dm_ack && last_beat) nstate = ST_DONE;
      ST_DONE: nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '0;
      wb_q   <= '0;
      dest_q <= '0;
      base_q <= '0;
      aluv_q <= '0;
      r2e_q  <= '0;
      r2v_q  <= '0;
      lde_q  <= '0;
      ldv_q  <= '0;
`ifdef VMEM_ALIGN_CHECK_EN
      aerr_q <= 1'b0;
`endif
    end else if (accept) begin
      mem_q  <= mem[2:0];
      wb_q   <= wb;
      dest_q <= dest;
      base_q <= resALUe;
      aluv_q <= resALUve;
      r2e_q  <= r2e;
      r2v_q  <= r2v;
      lde_q  <= '0;
      ldv_q  <= '0;
`ifdef VMEM_ALIGN_CHECK_EN
      aerr_q <= is_access && misalign;
`endif
    end else if (beat_done && rd_only) begin
      if (mem_q[MEM_VEC]) begin
        ldv_q[lane*LANE_W +: LANE_W] <= dm_rdata;
      end else begin
        lde_q <= dm_rdata[ADDR_W-1:0];
      end
    end
  end

  // Outputs are state-decoded so the port is quiet outside XFER and the bundle only shows in DONE.
  always_comb begin
    in_ready     = 1'b0;
    dm_req       = 1'b0;
    dm_we        = 1'b0;
    dm_addr      = '0;
    dm_wdata     = '0;
    out_valid    = 1'b0;
    wb_out       = '0;
    dest_out     = '0;
    resALUe_out  = '0;
    resALUve_out = '0;
    lde_out      = '0;
    ldv_out      = '0;
`ifdef VMEM_ALIGN_CHECK_EN
    align_err    = 1'b0;
`endif
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_XFER: begin
        dm_req   = 1'b1;
        dm_we    = mem_q[MEM_WR];
        dm_addr  = lane_addr;
        dm_wdata = mem_q[MEM_VEC] ? get_lane(r2v_q, lane) : LANE_W'(r2e_q);
      end
      ST_DONE: begin
        out_valid    = 1'b1;
        wb_out       = wb_q;
        dest_out     = dest_q;
        resALUe_out  = base_q;
        resALUve_out = aluv_q;
        lde_out      = lde_q;
        ldv_out      = ldv_q;
`ifdef VMEM_ALIGN_CHECK_EN
        align_err    = aerr_q;
`endif
      end
      default: ;
    endcase
  end

  assign stall = ~in_ready;

endmodule

// File: tb/tb_mem_stage_seq.sv
// tb/tb_mem_stage_seq.sv - table-driven and randomized self-checking bench for mem_stage_seq
// Honours VMEM_ALIGN_CHECK_EN when the design is built with it.
module tb_mem_stage_seq;

`ifdef VMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic         clk, rst, in_valid, in_ready;
  logic [3:0]   mem;
  logic [1:0]   wb;
  logic [20:0]  resALUe, r2e;
  logic [191:0] resALUve, r2v;
  logic [3:0]   dest;
  logic         dm_req, dm_we, dm_ack;
  logic [20:0]  dm_addr;
  logic [23:0]  dm_wdata, dm_rdata;
  logic         out_valid, stall;
  logic [1:0]   wb_out;
  logic [3:0]   dest_out;
  logic [20:0]  resALUe_out, lde_out;
  logic [191:0] resALUve_out, ldv_out;
`ifdef VMEM_ALIGN_CHECK_EN
  logic         align_err;
`endif

  mem_stage_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mem(mem), .wb(wb), .resALUe(resALUe), .resALUve(resALUve),
    .r2e(r2e), .r2v(r2v), .dest(dest),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .out_valid(out_valid), .wb_out(wb_out), .dest_out(dest_out),
    .resALUe_out(resALUe_out), .resALUve_out(resALUve_out),
    .lde_out(lde_out), .ldv_out(ldv_out),
`ifdef VMEM_ALIGN_CHECK_EN
    .align_err(align_err),
`endif
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] dmem [int];

  function automatic logic [23:0] rd_word(input logic [20:0] a);
    if (dmem.exists(int'(a))) return dmem[int'(a)];
    return {3'b101, a};
  endfunction

  function automatic logic [191:0] rand_vec();
    logic [191:0] v;
    for (int i = 0; i < 6; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // Reference model: the op is expanded into its list of beats and load results up front.
  task automatic run_op(input logic [3:0] m, input logic [20:0] base, input logic [20:0] se,
                        input logic [191:0] sv, input int waits, input int exp_lat,
                        output int obs_beats, output logic [20:0] obs_lde,
                        output logic [191:0] obs_ldv);
    logic [20:0]  ea [8];
    logic [23:0]  ed [8];
    logic [20:0]  e_lde;
    logic [191:0] e_ldv, aluv;
    logic [1:0]   wbv;
    logic [3:0]   dv;
    logic         is_wr, is_rd, is_vec, skip, e_aerr, got, stall_bad;
    int nb, cyc, beats, wcnt, tgt;
    is_wr  = m[1];
    is_rd  = m[0] & ~m[1];
    is_vec = m[2];
    e_aerr = ALIGN && (m[0] | m[1]) && is_vec && (base[2:0] != 3'b000);
    skip   = !(m[0] | m[1]) || e_aerr;
    nb     = skip ? 0 : (is_vec ? 8 : 1);
    e_lde  = '0;
    e_ldv  = '0;
    for (int i = 0; i < nb; i++) begin
      ea[i] = base + 21'(i);
      ed[i] = is_vec ? sv[i*24 +: 24] : {3'b000, se};
      if (is_rd) begin
        if (is_vec) e_ldv[i*24 +: 24] = rd_word(ea[i]);
        else        e_lde = rd_word(ea[i]) >> 0;
      end
    end
    if (is_rd && !is_vec && nb == 1) e_lde = rd_word(ea[0][20:0]);
    aluv = rand_vec();
    wbv  = 2'($urandom);
    dv   = 4'($urandom);

    chk("ready_idle", in_ready, 1);
    in_valid = 1'b1; mem = m; wb = wbv; resALUe = base; resALUve = aluv;
    r2e = se; r2v = sv; dest = dv;
    @(negedge clk);
    in_valid = 1'($urandom_range(0, 1));
    mem = 4'($urandom); wb = 2'($urandom); resALUe = 21'($urandom);
    resALUve = rand_vec(); r2e = 21'($urandom); r2v = rand_vec(); dest = 4'($urandom);

    cyc = 0; got = 0; beats = 0; wcnt = 0; tgt = 0; stall_bad = 0;
    while (!got && cyc < 300) begin
      cyc++;
      if (out_valid) begin
        got = 1;
      end else begin
        if (!stall || in_ready) stall_bad = 1;
        if (dm_req) begin
          if (wcnt == 0) begin
            if (beats < nb) begin
              chk("beat_addr", dm_addr, ea[beats]);
              chk("beat_we", dm_we, is_wr);
              if (is_wr) chk("beat_wdata", dm_wdata, ed[beats]);
            end else begin
              chk("beat_overrun", beats, nb);
            end
            tgt = (waits < 0) ? $urandom_range(0, 2) : waits;
          end
          if (wcnt == tgt) begin
            dm_ack = 1'b1;
            dm_rdata = rd_word(dm_addr);
            if (dm_we) dmem[int'(dm_addr)] = dm_wdata;
            beats++;
            wcnt = 0;
          end else begin
            dm_ack = 1'b0;
            dm_rdata = 24'($urandom);
            wcnt++;
          end
        end else begin
          dm_ack = 1'($urandom_range(0, 1));
          dm_rdata = 24'($urandom);
        end
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    dm_ack = 1'b0;
    obs_beats = beats;
    obs_lde = lde_out;
    obs_ldv = ldv_out;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL out_valid_timeout: got none after %0d cycles expected pulse", cyc);
      return;
    end
    if (exp_lat >= 0) chk("latency", cyc, exp_lat);
    chk("stall_busy", stall_bad, 0);
    chk("ready_done", in_ready, 0);
    chk("beats", beats, nb);
    chk("lde_out", lde_out, e_lde);
    chk("ldv_out", ldv_out, e_ldv);
    chk("wb_out", wb_out, wbv);
    chk("dest_out", dest_out, dv);
    chk("resALUe_out", resALUe_out, base);
    chk("resALUve_out", resALUve_out, aluv);
`ifdef VMEM_ALIGN_CHECK_EN
    chk("align_err", align_err, e_aerr);
`endif
    @(negedge clk);
    chk("pulse_width", out_valid, 0);
    chk("ready_after", in_ready, 1);
  endtask

  typedef struct {
    logic [3:0]   m;
    logic [20:0]  base;
    logic [20:0]  se;
    logic [191:0] sv;
    int           waits;
    int           beats;
    int           lat;
  } vec_t;

  vec_t         tbl[$];
  logic [191:0] seq18, rv;
  logic [20:0]  lde_seen [16];
  logic [191:0] ldv_seen [16];

  initial begin
    int nbeats, guard, k, bad;
    logic [20:0] olde;
    logic [191:0] oldv;
    logic [3:0] rm;
    logic [20:0] rb;

    rst = 1'b1; in_valid = 1'b0; mem = '0; wb = '0; resALUe = '0; resALUve = '0;
    r2e = '0; r2v = '0; dest = '0; dm_ack = 1'b0; dm_rdata = '0;
    for (int i = 0; i < 8; i++) seq18[i*24 +: 24] = 24'(i + 1);

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_dm_req", dm_req, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ldv", ldv_out, 0);
    chk("rst_lde", lde_out, 0);
`ifdef VMEM_ALIGN_CHECK_EN
    chk("rst_align_err", align_err, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    dmem[32'h100] = 24'hF12345;
    tbl.push_back('{4'b0000, 21'h00ABC, 21'h0,      '0,    0, 0, 1});
    tbl.push_back('{4'b0110, 21'h00010, 21'h0,      seq18, 0, 8, 9});
    tbl.push_back('{4'b0001, 21'h00100, 21'h0,      '0,    3, 1, 5});
    tbl.push_back('{4'b0101, 21'h00010, 21'h0,      '0,    0, 8, 9});
    tbl.push_back('{4'b0101, 21'h1FFFFC, 21'h0,     '0,    1, 8, 17});
    tbl.push_back('{4'b0010, 21'h00200, 21'h1ABCDE, '0,    2, 1, 4});
    tbl.push_back('{4'b0011, 21'h00300, 21'h0F0F0F, '0,    0, 1, 2});
    tbl.push_back('{4'b1000, 21'h00055, 21'h0,      '0,    0, 0, 1});
    tbl.push_back('{4'b0100, 21'h00066, 21'h0,      '0,    0, 0, 1});
    tbl.push_back('{4'b0101, 21'h00013, 21'h0,      '0,    0, ALIGN ? 0 : 8, ALIGN ? 1 : 9});
    tbl.push_back('{4'b0110, 21'h1FFFFD, 21'h0, seq18,     0, ALIGN ? 0 : 8, ALIGN ? 1 : 9});

    foreach (tbl[i]) begin
      run_op(tbl[i].m, tbl[i].base, tbl[i].se, tbl[i].sv, tbl[i].waits, tbl[i].lat,
             nbeats, olde, oldv);
      chk("table_beats", nbeats, tbl[i].beats);
      lde_seen[i] = olde;
      ldv_seen[i] = oldv;
    end
    chk("plan_scalar_lde", lde_seen[2], 21'h112345);
    chk("plan_vector_readback", ldv_seen[3], seq18);
    chk("plan_write_wins_lde", lde_seen[6], 0);
    if (ALIGN) chk("plan_misaligned_ldv", ldv_seen[9], 0);

    // Reset dropped on the bus while lane 4 of a vector store is being presented.
    rv = rand_vec();
    in_valid = 1'b1; mem = 4'b0110; resALUe = 21'h00040; r2v = rv;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0; guard = 0;
    while (k < 4 && guard < 20) begin
      if (dm_req) begin
        dmem[int'(dm_addr)] = dm_wdata;
        dm_ack = 1'b1;
        k++;
      end else begin
        dm_ack = 1'b0;
      end
      guard++;
      @(negedge clk);
    end
    chk("rst_mid_lane4_addr", dm_addr, 21'h00044);
    chk("rst_mid_lane4_data", dm_wdata, rv[4*24 +: 24]);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_req_drop", dm_req, 0);
    chk("rst_mid_no_valid", out_valid, 0);
    dm_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid || dm_req) bad = 1;
    end
    chk("rst_mid_quiet", bad, 0);
    chk("rst_mid_ready", in_ready, 1);
    run_op(4'b0101, 21'h00040, 21'h0, '0, 0, 9, nbeats, olde, oldv);
    chk("rst_mid_partial_kept", oldv[3*24 +: 24], rv[3*24 +: 24]);

    for (int n = 0; n < 40; n++) begin
      rm = 4'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 21'h1FFFF8 + 21'($urandom_range(0, 7)) : 21'($urandom);
      run_op(rm, rb, 21'($urandom), rand_vec(), -1, -1, nbeats, olde, oldv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
